// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM stage of the 5-stage RV32 pipeline. Runs LW/SW word
//                accesses on a valid/ready data-memory port with a variable
//                latency response, stalls the upstream stages while an
//                access is in flight, and owns the MEM/WB pipeline register.
//                Misaligned accesses are flagged without touching the bus;
//                accesses that exceed TIMEOUT_CYCLES are aborted as bus errors.
//  Ports       : clk, reset                 - clock / sync active-high reset
//                pc_in .. mem_write_in      - EX/MEM register fields
//                dmem_req_* / dmem_resp_*   - data-memory request/response
//                mem_stall                  - freeze PC/IF/ID/ID-EX/EX-MEM
//                pc_out .. bus_err_out      - MEM/WB register fields
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_resp_rdata,
    output logic        mem_stall,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_we;
    logic             r_timeout;

    logic w_mem_op;
    logic w_misalign;
    logic w_timeout_hit;
    logic w_stall;
    logic w_req_valid;
    logic w_capture_rdata;
    logic w_set_timeout;
    logic w_bus_err;

    assign w_mem_op      = mem_read_in | mem_write_in;
    assign w_misalign    = w_mem_op & (alu_result_in[1:0] != 2'b00);
    // Last permitted bus cycle: a handshake here still wins over the abort.
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_bus_err     = (r_state == S_DONE) & r_timeout;

    always_comb begin
        w_state_nxt     = r_state;
        w_stall         = 1'b0;
        w_req_valid     = 1'b0;
        w_capture_rdata = 1'b0;
        w_set_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_misalign) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_stall     = 1'b1;
                w_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    w_state_nxt = r_we ? S_DONE : S_RESP;
                end else if (w_timeout_hit) begin
                    w_state_nxt   = S_DONE;
                    w_set_timeout = 1'b1;
                end
            end
            S_RESP: begin
                w_stall = 1'b1;
                if (dmem_resp_valid) begin
                    w_capture_rdata = 1'b1;
                    w_state_nxt     = S_DONE;
                end else if (w_timeout_hit) begin
                    w_state_nxt   = S_DONE;
                    w_set_timeout = 1'b1;
                end
            end
            S_DONE: begin
                // EX/MEM advances on this edge together with MEM/WB.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset must silence the bus and the pipeline freeze immediately.
    assign mem_stall      = w_stall & ~reset;
    assign dmem_req_valid = w_req_valid & ~reset;
    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = r_addr;
    assign dmem_req_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_rdata        <= 32'd0;
            r_we           <= 1'b0;
            r_timeout      <= 1'b0;
            pc_out         <= 32'd0;
            alu_result_out <= 32'd0;
            mem_data_out   <= 32'd0;
            rd_out         <= 5'd0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            misalign_out   <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == S_REQ) || (r_state == S_RESP)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
                r_addr  <= {alu_result_in[31:2], 2'b00};
                r_wdata <= rs2_data_in;
                r_we    <= mem_write_in;
            end

            if (w_capture_rdata) begin
                r_rdata <= dmem_resp_rdata;
            end

            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_timeout <= 1'b0;
            end

            // MEM/WB register: bubble while stalled, otherwise capture the op.
            if (w_stall) begin
                pc_out         <= 32'd0;
                alu_result_out <= 32'd0;
                mem_data_out   <= 32'd0;
                rd_out         <= 5'd0;
                reg_write_out  <= 1'b0;
                mem_to_reg_out <= 1'b0;
                misalign_out   <= 1'b0;
                bus_err_out    <= 1'b0;
            end else begin
                pc_out         <= pc_in;
                alu_result_out <= alu_result_in;
                mem_data_out   <= ((r_state == S_DONE) && !r_timeout && !r_we) ? r_rdata : 32'd0;
                rd_out         <= rd_in;
                reg_write_out  <= reg_write_in & ~w_misalign & ~w_bus_err;
                mem_to_reg_out <= mem_read_in;
                misalign_out   <= w_misalign;
                bus_err_out    <= w_bus_err;
            end
        end
    end

endmodule
`default_nettype wire
